// File: rtl/line_feed_sequencer.sv
// Frame-level feeder for the 4-line-buffer 3x3 window generator: pads one zero
// line above and below the image, gates line starts on buffer credits, and counts line-done interrupts.
module line_feed_sequencer #(
    parameter int LINE_W  = 512,
    parameter int IMG_H   = 512,
    parameter int NUM_BUF = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_s_data,
    input  logic       i_s_valid,
    output logic       o_s_ready,
    output logic [7:0] o_pixel_data,
    output logic       o_pixel_data_valid,
    input  logic       i_intr,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic [2:0] o_credits,
    output logic       o_err,
    output logic [2:0] o_dbg_state
);

    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int LN_W  = $clog2(IMG_H + 3);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
    localparam logic [LN_W-1:0]  LN_IMG   = LN_W'(IMG_H);
    localparam logic [2:0]       CRED_MAX = 3'(NUM_BUF);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAD_TOP = 3'd1,
        S_STREAM  = 3'd2,
        S_PAD_BOT = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [COL_W-1:0] r_col;
    logic [LN_W-1:0]  r_line;
    logic [LN_W-1:0]  r_intr_cnt;
    logic [2:0]       r_credits;
    logic             r_err;
    logic [7:0]       r_pix_data;
    logic             r_pix_valid;

    logic w_line_ok;
    logic w_pad;
    logic w_s_ready;
    logic w_emit;
    logic w_line_start;
    logic w_line_end;
    logic w_intr_ok;
    logic w_cred_inc;
    logic w_start;

    // Source handshake: a beat moves on a rising edge where i_s_valid and o_s_ready
    // are both high; o_s_ready never looks at i_s_valid, only at state, col and credits.
    assign w_line_ok    = (r_col != '0) || (r_credits != 3'd0);
    assign w_pad        = (r_state == S_PAD_TOP) || (r_state == S_PAD_BOT);
    assign w_s_ready    = (r_state == S_STREAM) && w_line_ok;
    assign w_emit       = (w_pad && w_line_ok) || (w_s_ready && i_s_valid);
    assign w_line_start = w_emit && (r_col == '0);
    assign w_line_end   = w_emit && (r_col == COL_LAST);
    assign w_intr_ok    = i_intr && (r_state != S_IDLE);
    assign w_cred_inc   = w_intr_ok && (r_credits != CRED_MAX);
    assign w_start      = i_start && (r_state == S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_nxt = S_PAD_TOP;
            S_PAD_TOP: if (w_line_end) w_state_nxt = S_STREAM;
            // r_line already holds the top pad line, so IMG_H means the last image line
            S_STREAM:  if (w_line_end && (r_line == LN_IMG)) w_state_nxt = S_PAD_BOT;
            S_PAD_BOT: if (w_line_end) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (r_intr_cnt >= LN_IMG) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = 1'b0;
        o_frame_done = 1'b0;
        o_s_ready    = w_s_ready;
        case (r_state)
            S_PAD_TOP, S_STREAM, S_PAD_BOT, S_DRAIN: o_busy = 1'b1;
            S_DONE:  o_frame_done = 1'b1;
            default: o_busy = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col  <= '0;
            r_line <= '0;
        end else if (w_start) begin
            r_col  <= '0;
            r_line <= '0;
        end else if (w_emit) begin
            r_col  <= w_line_end ? '0 : r_col + COL_W'(1);
            r_line <= w_line_end ? r_line + LN_W'(1) : r_line;
        end
    end

    // Saturating so stray interrupts can never wrap the counter back below IMG_H.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_intr_cnt <= '0;
        end else if (w_start) begin
            r_intr_cnt <= '0;
        end else if (w_intr_ok && (r_intr_cnt != '1)) begin
            r_intr_cnt <= r_intr_cnt + LN_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_credits <= 3'd0;
            r_err     <= 1'b0;
        end else if (w_start) begin
            r_credits <= CRED_MAX;
            r_err     <= 1'b0;
        end else begin
            if (w_cred_inc && !w_line_start) begin
                r_credits <= r_credits + 3'd1;
            end else if (!w_cred_inc && w_line_start) begin
                r_credits <= r_credits - 3'd1;
            end
            if (w_intr_ok && (r_credits == CRED_MAX)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_valid <= 1'b0;
            r_pix_data  <= 8'd0;
        end else begin
            r_pix_valid <= w_emit;
            if (w_emit) begin
                r_pix_data <= w_pad ? 8'd0 : i_s_data;
            end
        end
    end

    assign o_pixel_data       = r_pix_data;
    assign o_pixel_data_valid = r_pix_valid;
    assign o_credits          = r_credits;
    assign o_err              = r_err;
    assign o_dbg_state        = r_state;

endmodule

// File: doc/line_feed_sequencer.md
# line_feed_sequencer

Frame-level controller that feeds the 4-line-buffer 3x3 window generator. It admits pixels from an upstream source one line at a time under a buffer-credit scheme, and injects one zero padding line above and below the image. It counts the window generator's line-done interrupts and signals end-of-frame. It sits between the pixel source (DMA/stream) and the window generator's pixel input and interrupt output.

## Interface
- LINE_W, 512: pixels per line; must match the window generator line length.
- IMG_H, 512: image rows per frame, range 1..1021.
- NUM_BUF, 4: line buffers in the window generator; this is the initial credit count.
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst_n  in  1  asynchronous, active-low reset; one clock.
- i_start  in  1  1-cycle pulse that starts a frame; ignored while o_busy=1.
- i_s_data  in  8  source pixel.
- i_s_valid  in  1  source pixel valid.
- o_s_ready  out  1  source ready; a beat transfers when i_s_valid & o_s_ready.
- o_pixel_data  out  8  pixel to the window generator.
- o_pixel_data_valid  out  1  qualifies o_pixel_data.
- i_intr  in  1  window generator line-done pulse; frees one buffer.
- o_busy  out  1  high from the accepted i_start until o_frame_done.
- o_frame_done  out  1  1-cycle end-of-frame pulse.
- o_credits  out  3  free line buffers, range 0..NUM_BUF.
- o_err  out  1  sticky; i_intr arrived while credits=NUM_BUF.

## Operation
- **States:** IDLE, PAD_TOP, STREAM, PAD_BOT, DRAIN, DONE.
- **IDLE:** on i_start, set credits=NUM_BUF, clear col/line/intr counters and o_err, then go to PAD_TOP.
- **Line start rule (all feed states):** a line may start (col=0) only if credits>0. The first pixel of each line decrements credits. Mid-line pixels need no credit.
- **PAD_TOP:** emits LINE_W zero pixels, one per cycle, subject to the line start rule. After the last one, go to STREAM.
- **STREAM:** o_s_ready = (col!=0) | (credits!=0). Each accepted beat is forwarded. After IMG_H lines complete, go to PAD_BOT.
- **PAD_BOT:** same behaviour as PAD_TOP, then go to DRAIN.
- **Feed total:** IMG_H+2 lines per frame.
- **Column counter:** width clog2(LINE_W). It wraps from LINE_W-1 to 0 and increments the line counter.
- **Credit update:** each i_intr increments credits and the intr counter.
  - A simultaneous i_intr and line-start decrement leaves credits unchanged.
  - An i_intr at credits=NUM_BUF does not increment credits; it sets o_err.
- **DRAIN:** waits until intr counter = IMG_H, then goes to DONE. i_intr can arrive in any non-IDLE state and is counted.
- **DONE:** pulse o_frame_done for one cycle, drop o_busy, go to IDLE.
- **o_s_ready** is 0 in every state except STREAM.
- **Ignored inputs:** i_s_valid outside STREAM and i_intr in IDLE are ignored. i_intr in IDLE does not set o_err.

## Timing
- **Reset values:** all outputs 0; state IDLE; credits 0.
- **Reset mid-frame:** immediate return to IDLE with all outputs 0. No partial-line completion.
- **Start:** o_busy rises the cycle after i_start is sampled. The first pad pixel valid appears 2 cycles after i_start.
- **Output register:** o_pixel_data and o_pixel_data_valid are registered, giving 1-cycle latency from the accepted source beat or pad emission.
- **o_s_ready** is combinational from state, col and credits. It has no combinational path from i_s_valid.
- **o_credits** is registered and reflects updates one cycle after the event.
- **Throughput:** 1 pixel/cycle while credits allow.
- **End of frame:** the STREAM to PAD_BOT transition is on the cycle after the last image beat, with no bubble beyond that. o_frame_done is asserted the cycle after DRAIN sees intr counter = IMG_H.

## Test plan
- **Reset:** assert i_rst_n=0 asynchronously mid-cycle → all outputs 0 immediately. After release, still 0 and state IDLE.
- **Preload (LINE_W=4, IMG_H=3, NUM_BUF=4):** start, continuous source, no i_intr → exactly 16 valid pixels (4 zeros then 12 source pixels in order). Then o_s_ready=0 and o_credits=0.
- **Continue same config:** pulse i_intr once → 4 more zero pixels (PAD_BOT). Further i_intr pulses → o_frame_done one cycle after the 3rd i_intr total, then o_busy=0.
- **Source backpressure:** i_s_valid toggles 1010… in STREAM → output sequence equals the accepted data in order, with valid gaps matching. Column wrap and credit decrement happen only at true line starts.
- **Simultaneous events:** i_intr coincides with a line-start beat at credits=1 → credits stay 1 and no o_err. Then i_intr pulses until credits=NUM_BUF, then one extra i_intr → o_err=1, credits stay at NUM_BUF, and the next i_start clears o_err.
- **Start while busy:** an i_start pulse during STREAM is ignored. Counters are unaffected and the frame completes normally.
